// File: rtl/clk_div_ratio_ctrl_if.sv
// Request/acknowledge channel between a ratio requester and clk_div_ratio_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface clk_div_ratio_ctrl_if #(
  parameter int RATIO_W = 8
);
  logic               I_req;
  logic [RATIO_W-1:0] I_req_ratio;
  logic               o_busy;
  logic               o_ack;
  logic               o_err;

  modport master (
    output I_req, I_req_ratio,
    input  o_busy, o_ack, o_err
  );

  modport slave (
    input  I_req, I_req_ratio,
    output o_busy, o_ack, o_err
  );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Parks the integer clock divider at a low phase of its output, loads a new ratio, and re-enables it.
// Optional macro CLK_DIV_CTRL_ODD_REJECT_EN: odd ratios are rejected so that only even ratios are applied.
//
// state     | meaning
// BOOT      | enable held low for SETTLE_CYCLES after reset, then enable restored
// IDLE      | waiting for a ratio request
// CHECK     | request classified: reject, no change, or apply
// WAIT_EDGE | waiting for a divided-clock falling edge, bounded by EDGE_TIMEOUT
// LOAD      | enable low, new ratio driven to the divider
// SETTLE    | enable held low for SETTLE_CYCLES
// DONE      | ack (and err when rejected) pulse, busy released
module clk_div_ratio_ctrl #(
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int EDGE_TIMEOUT  = 1023
) (
  input  logic                 I_ref_clk,
  input  logic                 I_rst,
  clk_div_ratio_ctrl_if.slave  bus,
  input  logic                 I_div_clk,
  output logic                 o_clk_en,
  output logic [RATIO_W-1:0]   o_div_ratio
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TO_W  = (EDGE_TIMEOUT > 1) ? $clog2(EDGE_TIMEOUT) : 1;
  localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(EDGE_TIMEOUT - 1);
  localparam logic [RATIO_W-1:0] RATIO_DEF = RATIO_W'(DEFAULT_RATIO);
  localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(2);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_CHECK, S_WAIT_EDGE, S_LOAD, S_SETTLE, S_DONE
  } state_t;

  state_t             r_state;
  logic [RATIO_W-1:0] r_req;
  logic [RATIO_W-1:0] r_ratio;
  logic [SET_W-1:0]   r_set_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_div_q;
  logic               r_clk_en;
  logic               r_busy;
  logic               r_ack;
  logic               r_err;

  logic w_edge;
  logic w_reject;

  assign w_edge = r_div_q & ~I_div_clk;

`ifdef CLK_DIV_CTRL_ODD_REJECT_EN
  assign w_reject = (r_req < RATIO_MIN) | r_req[0];
`else
  assign w_reject = (r_req < RATIO_MIN);
`endif

  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      r_state   <= S_BOOT;
      r_req     <= '0;
      r_ratio   <= RATIO_DEF;
      r_set_cnt <= '0;
      r_to_cnt  <= '0;
      r_div_q   <= 1'b0;
      r_clk_en  <= 1'b0;
      r_busy    <= 1'b1;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_div_q <= I_div_clk;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_BOOT: begin
          if (r_set_cnt == SET_LAST) begin
            r_clk_en <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.I_req) begin
            r_req   <= bus.I_req_ratio;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_reject) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_req == r_ratio) begin
            r_ack   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_EDGE;
          end
        end
        S_WAIT_EDGE: begin
          // A stuck divided clock still gets parked once the timeout expires.
          if (w_edge || (r_to_cnt == TO_LAST)) begin
            r_clk_en <= 1'b0;
            r_state  <= S_LOAD;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_ratio   <= r_req;
          r_set_cnt <= '0;
          r_state   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            r_clk_en <= 1'b1;
            r_ack    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign o_clk_en    = r_clk_en;
  assign o_div_ratio = r_ratio;
  assign bus.o_busy  = r_busy;
  assign bus.o_ack   = r_ack;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Scoreboard bench for clk_div_ratio_ctrl: requests push expected outcomes, a monitor pops them on o_ack.
// A behavioural divider model drives I_div_clk from o_clk_en/o_div_ratio.
module tb_clk_div_ratio_ctrl;
  localparam int RW  = 8;
  localparam int DEF = 2;
  localparam int S   = 2;
  localparam int T   = 1023;
`ifdef CLK_DIV_CTRL_ODD_REJECT_EN
  localparam bit ODD_REJ = 1'b1;
`else
  localparam bit ODD_REJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          div_clk = 1'b0;
  logic          clk_en;
  logic [RW-1:0] ratio;

  clk_div_ratio_ctrl_if #(.RATIO_W(RW)) bus ();

  clk_div_ratio_ctrl #(
    .RATIO_W(RW), .DEFAULT_RATIO(DEF), .SETTLE_CYCLES(S), .EDGE_TIMEOUT(T)
  ) dut (
    .I_ref_clk  (clk),
    .I_rst      (rst),
    .bus        (bus.slave),
    .I_div_clk  (div_clk),
    .o_clk_en   (clk_en),
    .o_div_ratio(ratio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [RW-1:0] ratio;
    bit            changed;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  bit            stuck = 1'b0;
  logic [RW-1:0] model_ratio = DEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: output high for the first half of each ratio period while enabled.
  initial begin
    int dcnt;
    int r;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (stuck) div_clk = 1'b1;
      else if (clk_en === 1'b1) begin
        r = (int'(ratio) < 2) ? 2 : int'(ratio);
        dcnt = (dcnt + 1) % r;
        div_clk = (dcnt < r / 2);
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t          e;
    bit            in_boot = 1'b1;
    int            rel = 0;
    int            acc = -1;
    int            fall = -1000;
    logic          pen = 1'b0;
    logic          pbusy = 1'b1;
    logic          pdiv = 1'b0;
    logic [RW-1:0] pratio = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        check("reset_clk_en", clk_en, 0);
        check("reset_ratio", ratio, DEF);
        check("reset_busy", bus.o_busy, 1);
        check("reset_ack", bus.o_ack, 0);
        in_boot = 1'b1;
        rel = cyc;
        acc = -1;
      end else begin
        if (bus.I_req && !pbusy) acc = cyc;
        if (pen && !clk_en) begin
          fall = cyc;
          if (stuck) check("timeout_wait", cyc - acc, 1 + T);
          else check("edge_align", {pdiv, div_clk}, 2'b10);
        end
        if (!pen && clk_en && in_boot) begin
          check("boot_len", cyc - rel, S);
          check("boot_busy", bus.o_busy, 0);
          in_boot = 1'b0;
        end
        if (ratio != pratio) begin
          check("ratio_chg_en_low", clk_en, 0);
          check("ratio_after_fall", cyc - fall, 1);
        end
        if (bus.o_ack) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ack with err=%0d ratio=%0d, expected none (cycle %0d)",
                     bus.o_err, ratio, cyc);
          end else begin
            e = sb.pop_front();
            check("ack_err", bus.o_err, e.err);
            check("ack_ratio", ratio, e.ratio);
            if (e.changed) begin
              check("settle_len", cyc - fall, S + 1);
              check("en_at_ack", clk_en, 1);
            end else begin
              check("ack_latency", cyc - acc, 1);
              check("no_en_drop", fall < acc, 1);
            end
          end
        end
      end
      pen    = clk_en;
      pbusy  = bus.o_busy;
      pdiv   = div_clk;
      pratio = ratio;
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (bus.o_busy !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy still %0d, expected 0", bus.o_busy);
    end
  endtask

  // Issues one accepted request and records its expected outcome from the ratio rules.
  task automatic issue(input logic [RW-1:0] r);
    exp_t e;
    wait_idle();
    if (r < 2 || (ODD_REJ && r[0])) e = '{err: 1'b1, ratio: model_ratio, changed: 1'b0};
    else if (r == model_ratio)      e = '{err: 1'b0, ratio: model_ratio, changed: 1'b0};
    else                            e = '{err: 1'b0, ratio: r, changed: 1'b1};
    model_ratio = e.ratio;
    sb.push_back(e);
    bus.I_req       = 1'b1;
    bus.I_req_ratio = r;
    @(negedge clk);
    bus.I_req = 1'b0;
  endtask

  task automatic wait_ack();
    int w;
    w = 0;
    while (bus.o_ack !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: ack %0d, expected 1", bus.o_ack);
    end
  endtask

  task automatic request(input logic [RW-1:0] r, input bit extra);
    issue(r);
    if (extra) begin
      repeat (2) @(negedge clk);
      bus.I_req       = 1'b1;
      bus.I_req_ratio = 8'd9;
      @(negedge clk);
      bus.I_req = 1'b0;
    end
    wait_ack();
  endtask

  initial begin
    logic [RW-1:0] r;
    int w;
    bus.I_req       = 1'b0;
    bus.I_req_ratio = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    request(8'd4, 1'b0);
    request(8'd0, 1'b0);
    request(8'd1, 1'b0);
    request(8'd3, 1'b0);

    stuck = 1'b1;
    repeat (3) @(negedge clk);
    request(8'd6, 1'b0);
    stuck = 1'b0;

    request(8'd8, 1'b1);
    repeat (4) @(negedge clk);
    request(8'd8, 1'b0);

    for (int i = 0; i < 25; i++) begin
      r = RW'($urandom_range(0, 12));
      request(r, 1'b0);
    end

    // Reset during SETTLE: request abandoned, no ack, boot repeats.
    r = (model_ratio == 8'd10) ? 8'd12 : 8'd10;
    issue(r);
    w = 0;
    while (clk_en !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL park_timeout: clk_en %0d, expected 0", clk_en);
    end
    @(negedge clk);
    sb.delete();
    model_ratio = DEF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    request(8'd4, 1'b0);
    request(8'd5, 1'b0);
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/clk_div_ratio_ctrl.md
Name: clk_div_ratio_ctrl

Overview:
- Sequencer that owns the configuration inputs of the integer clock divider: its clock enable and its division ratio.
- Accepts ratio-change requests over a request/acknowledge handshake and rejects illegal ratios (0, 1).
- Applies a legal ratio only while the divider is parked: enable dropped at a low phase of the divided clock, ratio loaded, settle time, enable restored.
- Same clock domain as the divider's reference clock; the divided clock is fed back as a plain synchronous input.

Parameters:
- RATIO_W, 8, width of the division ratio.
- DEFAULT_RATIO, 2, ratio driven out of reset; must be >= 2.
- SETTLE_CYCLES, 2, reference cycles enable is held low after a ratio load; must be >= 1.
- EDGE_TIMEOUT, 1023, maximum cycles spent waiting for a divided-clock falling edge.

Ports:
- I_ref_clk  input  1  reference clock; all logic on its rising edge.
- I_rst  input  1  synchronous, active-high reset.
- I_req  input  1  ratio-change request; sampled only in IDLE.
- I_req_ratio  input  RATIO_W  requested ratio; captured with I_req.
- I_div_clk  input  1  divider output fed back for phase detection.
- o_clk_en  output  1  drives the divider clock enable.
- o_div_ratio  output  RATIO_W  drives the divider ratio input.
- o_busy  output  1  high while a request or the boot sequence is in progress.
- o_ack  output  1  one-cycle pulse when a request completes.
- o_err  output  1  one-cycle pulse coincident with o_ack when the request was rejected.

Behaviour:
- Reset (I_rst high at a clock edge):
  - o_clk_en=0, o_div_ratio=DEFAULT_RATIO, o_busy=1, o_ack=0, o_err=0.
  - State BOOT, counters cleared, edge-detect flop cleared.
  - Reset mid-operation abandons any request: no ack is issued and the ratio returns to DEFAULT_RATIO.
- States: BOOT, IDLE, CHECK, WAIT_EDGE, LOAD, SETTLE, DONE.
- BOOT: count SETTLE_CYCLES cycles, then o_clk_en<=1, o_busy<=0, go to IDLE.
- IDLE:
  - If I_req=1: capture I_req_ratio into req_r, o_busy<=1, go to CHECK.
  - Otherwise hold state.
- CHECK (1 cycle):
  - req_r<2: reject, go to DONE with err flag set.
  - req_r==o_div_ratio: no change, go to DONE with err clear; o_clk_en untouched.
  - Otherwise go to WAIT_EDGE and clear the timeout counter.
- WAIT_EDGE:
  - Falling-edge detect: div_q<=I_div_clk every cycle; edge when div_q=1 and I_div_clk=0.
  - On edge: o_clk_en<=0, go to LOAD.
  - If the timeout counter reaches EDGE_TIMEOUT first (e.g. divided clock stuck), same action: o_clk_en<=0, go to LOAD. This is not an error.
- LOAD (1 cycle): o_div_ratio<=req_r; reset the settle counter; go to SETTLE.
- SETTLE: after SETTLE_CYCLES cycles, o_clk_en<=1 and go to DONE.
- DONE (1 cycle): o_ack=1, o_err=err flag, o_busy<=0, go to IDLE.
  - o_ack and o_err are registered and high for exactly this cycle.
- Latency:
  - Rejected or unchanged request: I_req sampled at edge N, o_ack high in cycle N+2.
  - Legal change: N+2 + edge wait + 1 (LOAD) + SETTLE_CYCLES + 1.
- I_req while o_busy=1 is ignored: not queued, not acknowledged. The requester must wait for o_ack.
  - I_req held high in the DONE cycle is not accepted; it is accepted on the next IDLE cycle.
- o_div_ratio changes only in LOAD, and only while o_clk_en=0.
- o_clk_en is never low outside WAIT_EDGE exit, LOAD, SETTLE and BOOT.

Optional Feature:
- Macro: CLK_DIV_CTRL_ODD_REJECT_EN.
- Defined: CHECK also rejects odd req_r (req_r[0]=1) with o_err=1, so only 50%-duty even ratios are applied. DEFAULT_RATIO must then be even.
- Undefined: any req_r >= 2 is legal.

Test Plan:
- Reset/boot: hold I_rst 3 cycles, release -> o_div_ratio=2, o_clk_en=0 for 2 cycles then 1, o_busy falls with it, o_ack never pulses.
- Legal even change: I_req with ratio 4 while running at 2 -> o_clk_en drops in the cycle after a falling edge of I_div_clk, o_div_ratio=4 in LOAD, o_clk_en=1 after 2 settle cycles, one o_ack pulse with o_err=0.
- Corner ratios: requests for 0, then 1 -> each gets o_ack with o_err=1 two cycles after request; o_div_ratio stays 4; o_clk_en never drops.
- Odd ratio 3: macro off -> applied, o_err=0. Macro on -> o_err=1 and ratio unchanged.
- Stuck divided clock: hold I_div_clk=1, request ratio 6 -> o_clk_en drops exactly EDGE_TIMEOUT cycles after entering WAIT_EDGE, ratio becomes 6, o_err=0.
- Busy/reset interplay:
  - Second I_req while busy -> ignored, exactly one o_ack.
  - I_rst asserted during SETTLE -> no o_ack, o_div_ratio=2, boot sequence repeats.
